// File: rtl/latency_pkg.sv
// Shared constants for the latency meter: marker default, FSM encodings, latency width.
// Pure declarations, no logic.
package latency_pkg;

    localparam int          LAT_W          = 32;
    localparam logic [31:0] MARKER_DEFAULT = 32'hABCDBEEF;

    localparam logic [0:0]  S_BODY = 1'b0;
    localparam logic [0:0]  S_TS   = 1'b1;

    // Ingress timestamps wrap, so the difference is taken modulo 2^LAT_W.
    function automatic logic [LAT_W-1:0] lat_delta(input logic [LAT_W-1:0] now,
                                                   input logic [LAT_W-1:0] ts);
        return now - ts;
    endfunction

endpackage

// File: rtl/latency_skid.sv
// Two-entry AXI-stream skid buffer: 1 cycle in->out, full rate with o_tready high.
// Registered i_tready drops only while both entries hold data; output is held until taken.
module latency_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    logic [WIDTH-1:0] r_out_dat, r_skid_dat;
    logic             r_out_last, r_skid_last;
    logic             r_out_vld, r_skid_vld;
    logic             r_rdy;

    logic [WIDTH-1:0] w_out_dat_nxt, w_skid_dat_nxt;
    logic             w_out_last_nxt, w_skid_last_nxt;
    logic             w_out_vld_nxt, w_skid_vld_nxt;
    logic             w_in_hs, w_out_hs;

    assign w_in_hs  = i_tvalid & r_rdy;
    assign w_out_hs = r_out_vld & o_tready;

    always_comb begin
        w_out_dat_nxt   = r_out_dat;
        w_out_last_nxt  = r_out_last;
        w_out_vld_nxt   = r_out_vld;
        w_skid_dat_nxt  = r_skid_dat;
        w_skid_last_nxt = r_skid_last;
        w_skid_vld_nxt  = r_skid_vld;
        if (!r_out_vld || w_out_hs) begin
            // Output slot frees up: the older skid entry has priority over new input.
            if (r_skid_vld) begin
                w_out_dat_nxt  = r_skid_dat;
                w_out_last_nxt = r_skid_last;
                w_out_vld_nxt  = 1'b1;
                w_skid_vld_nxt = 1'b0;
            end else begin
                w_out_vld_nxt = w_in_hs;
                if (w_in_hs) begin
                    w_out_dat_nxt  = i_tdata;
                    w_out_last_nxt = i_tlast;
                end
            end
        end else if (w_in_hs) begin
            w_skid_dat_nxt  = i_tdata;
            w_skid_last_nxt = i_tlast;
            w_skid_vld_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_dat   <= '0;
            r_out_last  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_skid_dat  <= '0;
            r_skid_last <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_rdy       <= 1'b1;
        end else begin
            r_out_dat   <= w_out_dat_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_vld   <= w_out_vld_nxt;
            r_skid_dat  <= w_skid_dat_nxt;
            r_skid_last <= w_skid_last_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
            r_rdy       <= !w_skid_vld_nxt;
        end
    end

    assign i_tready = r_rdy;
    assign o_tdata  = r_out_dat;
    assign o_tlast  = r_out_last;
    assign o_tvalid = r_out_vld;

endmodule

// File: rtl/latency_meter.sv
// Pass-through stage that finds MARKER+timestamp pairs and keeps last/min/max/count latency stats.
// Data 1 cycle via the skid buffer (backpressure from o_tready); stats update 1 cycle after the timestamp.
module latency_meter
    import latency_pkg::*;
#(
    parameter logic [31:0] MARKER = MARKER_DEFAULT,
    parameter int          CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [31:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    input  logic [63:0]      timer,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic [CNT_W-1:0] lat_count,
    output logic             lat_stb,
    output logic [15:0]      err_count
);

    logic             w_in_rdy;
    logic             w_hs, w_is_marker, w_ts_hs, w_err;
    logic [LAT_W-1:0] w_delta;
    logic             w_unused_timer_hi;

    logic [0:0]       r_state;
    logic [LAT_W-1:0] r_lat_last, r_lat_min, r_lat_max;
    logic [CNT_W-1:0] r_lat_count;
    logic             r_lat_stb;
    logic [15:0]      r_err_count;

    latency_skid #(.WIDTH(32)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (w_in_rdy),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    assign i_tready          = w_in_rdy;
    assign w_unused_timer_hi = ^timer[63:32];

    assign w_hs        = i_tvalid & w_in_rdy;
    assign w_is_marker = (i_tdata == MARKER);
    // In S_TS any word, MARKER included, is the timestamp.
    assign w_ts_hs     = w_hs & (r_state == S_TS);
    assign w_err       = w_hs & (r_state == S_BODY) & w_is_marker & i_tlast;
    assign w_delta     = lat_delta(timer[LAT_W-1:0], i_tdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_BODY;
            r_lat_last  <= '0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_lat_count <= '0;
            r_lat_stb   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_lat_stb <= w_ts_hs & !clear;
            if (clear) begin
                r_state     <= S_BODY;
                r_lat_last  <= '0;
                r_lat_min   <= '1;
                r_lat_max   <= '0;
                r_lat_count <= '0;
                r_err_count <= '0;
            end else begin
                if (w_ts_hs) begin
                    r_state    <= S_BODY;
                    r_lat_last <= w_delta;
                    if (w_delta < r_lat_min) r_lat_min <= w_delta;
                    if (w_delta > r_lat_max) r_lat_max <= w_delta;
                    if (r_lat_count != '1) r_lat_count <= r_lat_count + 1'b1;
                end else if (w_hs && w_is_marker && !i_tlast) begin
                    r_state <= S_TS;
                end
                if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign lat_last  = r_lat_last;
    assign lat_min   = r_lat_min;
    assign lat_max   = r_lat_max;
    assign lat_count = r_lat_count;
    assign lat_stb   = r_lat_stb;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_latency_meter.sv
// Scoreboard bench for latency_meter: output beats against a queue, statistics against hand-computed values.
module tb_latency_meter;
    import latency_pkg::*;

    localparam logic [31:0] MK = 32'hABCDBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [63:0] timer = '0;
    logic [31:0] lat_last, lat_min, lat_max, lat_count;
    logic        lat_stb;
    logic [15:0] err_count;

    int          rdy_mode = 0;
    logic        rdy_rnd = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stb_cnt = 0;
    bit          mon_en = 1'b0;
    logic [32:0] sb_q[$];
    logic [32:0] exp_beat;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    latency_meter #(.MARKER(MK), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .timer(timer),
        .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max),
        .lat_count(lat_count), .lat_stb(lat_stb), .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign o_tready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? rdy_rnd : 1'b0);

    always @(posedge clk) begin
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rdy_vs_occupancy", 64'(i_tready), 64'(sb_q.size() < 2));
            if (prev_stall) begin
                chk("hold_vld", 64'(o_tvalid), 64'd1);
                chk("hold_dat", 64'({o_tlast, o_tdata}), 64'(prev_beat));
            end
            if (o_tvalid && o_tready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_beat", 64'({o_tlast, o_tdata}), 64'h1_0000_0000_0);
                end else begin
                    exp_beat = sb_q.pop_front();
                    chk("beat", 64'({o_tlast, o_tdata}), 64'(exp_beat));
                end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_beat  = {o_tlast, o_tdata};
            if (lat_stb) stb_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic [31:0] tnow);
        int waitc;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        timer    = {32'hDEAD_0000 ^ 32'($urandom_range(0, 255)), tnow};
        waitc    = 0;
        @(negedge clk);
        while (!i_tready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!i_tready) begin
            chk("send_timeout", 64'(i_tready), 64'd1);
        end else begin
            @(posedge clk);
            sb_q.push_back({l, d});
        end
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic pkt(input logic [31:0] ts, input logic [31:0] tnow);
        send(MK, 1'b0, $urandom);
        send(ts, 1'b0, tnow);
        send(32'hA5, 1'b1, $urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic stats(input string p, input logic [31:0] el, input logic [31:0] emn,
                         input logic [31:0] emx, input logic [31:0] ec, input logic [15:0] ee);
        chk({p, ".last"}, 64'(lat_last), 64'(el));
        chk({p, ".min"}, 64'(lat_min), 64'(emn));
        chk({p, ".max"}, 64'(lat_max), 64'(emx));
        chk({p, ".count"}, 64'(lat_count), 64'(ec));
        chk({p, ".err"}, 64'(err_count), 64'(ee));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        l;

        #1 reset = 1'b1;
        #1;
        chk("rst.o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst.o_tdata", 64'(o_tdata), 64'd0);
        chk("rst.o_tlast", 64'(o_tlast), 64'd0);
        chk("rst.i_tready", 64'(i_tready), 64'd1);
        chk("rst.lat_stb", 64'(lat_stb), 64'd0);
        stats("rst", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single packet, delta 0x30
        send(32'h1, 1'b0, 32'h0);
        send(MK, 1'b0, 32'h77);
        send(32'h100, 1'b0, 32'h130);
        chk("t1.stb_now", 64'(lat_stb), 64'd1);
        send(32'h2, 1'b1, 32'h999);
        drain();
        stats("t1", 32'h30, 32'h30, 32'h30, 32'd1, 16'd0);
        chk("t1.stb_cnt", 64'(stb_cnt), 64'd1);

        do_clear();
        stats("clr", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);

        // Deltas 50, 10, 90
        pkt(32'd1000, 32'd1050);
        pkt(32'd2000, 32'd2010);
        pkt(32'd3000, 32'd3090);
        drain();
        stats("t3", 32'd90, 32'd10, 32'd90, 32'd3, 16'd0);

        pkt(32'hFFFF_FFFE, 32'h5);
        drain();
        stats("wrap", 32'd7, 32'd7, 32'd90, 32'd4, 16'd0);

        // Marker on a last beat, then a packet whose first word must not be a timestamp
        send(MK, 1'b1, 32'h10);
        send(32'h55, 1'b0, 32'h1000);
        send(32'h66, 1'b1, 32'h2000);
        drain();
        stats("err", 32'd7, 32'd7, 32'd90, 32'd4, 16'd1);

        // Timestamp word equal to MARKER
        send(MK, 1'b0, 32'h0);
        send(MK, 1'b0, MK + 32'd3);
        send(32'h10, 1'b1, 32'h4000);
        drain();
        stats("ts_mk", 32'd3, 32'd3, 32'd90, 32'd5, 16'd1);
        chk("stb_cnt6", 64'(stb_cnt), 64'd6);

        // Two entries buffered with the sink stalled
        rdy_mode = 2;
        send(32'h11, 1'b0, 32'h0);
        send(32'h22, 1'b0, 32'h0);
        @(negedge clk);
        chk("full.i_tready", 64'(i_tready), 64'd0);
        chk("full.o_tvalid", 64'(o_tvalid), 64'd1);
        chk("full.o_tdata", 64'(o_tdata), 64'h11);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send(32'h33, 1'b1, 32'h0);
        drain();

        // Random sink backpressure
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            if (d == MK) d = ~d;
            l = ($urandom_range(0, 7) == 0);
            send(d, l, $urandom);
        end
        drain();
        rdy_mode = 0;
        chk("rnd.count", 64'(lat_count), 64'd5);

        // Clear on the same cycle as the timestamp handshake
        send(MK, 1'b0, 32'h0);
        clear = 1'b1;
        send(32'h200, 1'b0, 32'h250);
        clear = 1'b0;
        send(32'h3, 1'b1, 32'h0);
        drain();
        stats("clr_ts", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);
        chk("clr_ts.stb_cnt", 64'(stb_cnt), 64'd6);

        // Async reset with a marker accepted and still buffered
        pkt(32'd500, 32'd600);
        drain();
        stats("pre_rst", 32'd100, 32'd100, 32'd100, 32'd1, 16'd0);
        rdy_mode = 2;
        send(MK, 1'b0, 32'h0);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        sb_q.delete();
        #1;
        chk("arst.o_tvalid", 64'(o_tvalid), 64'd0);
        chk("arst.o_tdata", 64'(o_tdata), 64'd0);
        chk("arst.o_tlast", 64'(o_tlast), 64'd0);
        chk("arst.i_tready", 64'(i_tready), 64'd1);
        chk("arst.lat_stb", 64'(lat_stb), 64'd0);
        stats("arst", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        reset    = 1'b0;
        mon_en   = 1'b1;
        send(32'h777, 1'b0, 32'h800);
        send(32'h888, 1'b1, 32'h900);
        drain();
        chk("post_rst.count", 64'(lat_count), 64'd0);
        chk("post_rst.last", 64'(lat_last), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
